// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared lane geometry and FSM state type for softmax_exp_accum
package softmax_pkg;
  localparam int LANES      = 8;
  localparam int LANE_W     = 8;
  localparam int BEAT_SUM_W = 11;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;
endpackage

// File: rtl/softmax_lane_adder.sv
// rtl/softmax_lane_adder.sv - combinational sum of the eight unsigned lanes of one beat
module softmax_lane_adder
  import softmax_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] i_data,
  output logic [BEAT_SUM_W-1:0]   o_sum
);

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      o_sum = o_sum + BEAT_SUM_W'(i_data[k*LANE_W +: LANE_W]);
    end
  end

endmodule

// File: rtl/softmax_exp_accum.sv
// rtl/softmax_exp_accum.sv - per-row accumulator of exp-LUT beats for softmax normalisation
// Optional clamping accumulator: define SOFTMAX_ACC_SAT_EN (default build wraps modulo 2^SUM_W).
module softmax_exp_accum
  import softmax_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int SUM_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [63:0]                    in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SUM_W-1:0]               out_sum,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
  output logic                           out_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SUM_W:0]          r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic [BEAT_SUM_W-1:0]   w_beat_sum;
  logic [SUM_W:0]          w_acc_add;
  logic [SUM_W:0]          w_acc_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_accept;
  logic                    w_out_hs;
  logic                    w_at_limit;

  softmax_lane_adder u_lane_adder (
    .i_data (in_data),
    .o_sum  (w_beat_sum)
  );

  assign in_ready   = (r_state == ST_ACC);
  assign out_valid  = (r_state == ST_OUT);
  assign w_accept   = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_at_limit = (w_cnt_nxt == CNT_W'(MAX_BEATS));
  assign w_acc_add  = r_acc + (SUM_W+1)'(w_beat_sum);

  // Top accumulator bit is the carry out of the SUM_W-bit sum; it is never stored set.
`ifdef SOFTMAX_ACC_SAT_EN
  assign w_acc_nxt = w_acc_add[SUM_W] ? {1'b0, {SUM_W{1'b1}}} : w_acc_add;
`else
  assign w_acc_nxt = w_acc_add & {1'b0, {SUM_W{1'b1}}};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && (in_last || w_at_limit)) w_state_nxt = ST_OUT;
      ST_OUT:  if (w_out_hs) w_state_nxt = ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_at_limit && !in_last;
    end else if (w_out_hs) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end
  end

  assign out_sum   = r_acc[SUM_W-1:0];
  assign out_beats = r_cnt;
  assign out_err   = r_err;

endmodule

// File: tb/tb_softmax_exp_accum.sv
// tb/tb_softmax_exp_accum.sv - self-checking bench: vector table, corner sequences, random rows vs model
module tb_softmax_exp_accum;

  localparam int MAXB  = 16;
  localparam int SW    = 16;
  localparam int SW12  = 12;
  localparam int CW    = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [63:0]   in_data = '0;
  logic          in_ready, out_valid, out_err;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_beats;

  logic            v12 = 1'b0, l12 = 1'b0, r12 = 1'b0;
  logic [63:0]     d12 = '0;
  logic            rdy12, ov12, err12;
  logic [SW12-1:0] sum12;
  logic [CW-1:0]   beats12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  softmax_exp_accum #(.MAX_BEATS(MAXB), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_beats(out_beats), .out_err(out_err)
  );

  softmax_exp_accum #(.MAX_BEATS(MAXB), .SUM_W(SW12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(v12), .in_ready(rdy12), .in_data(d12),
    .in_last(l12), .out_valid(ov12), .out_ready(r12), .out_sum(sum12),
    .out_beats(beats12), .out_err(err12)
  );

  typedef struct {
    int         nbeats;
    logic [7:0] lane;
    bit         last;
    int         exp_sum;
    int         exp_beats;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Reference: a row's result is the plain total of all its bytes, reduced by the build mode.
  function automatic int model_sum(input logic [63:0] q[$], input int w);
    longint total = 0;
    longint lim = (longint'(1) << w);
    foreach (q[i]) for (int k = 0; k < 8; k++) total += q[i][8*k +: 8];
`ifdef SOFTMAX_ACC_SAT_EN
    return int'((total > lim - 1) ? lim - 1 : total);
`else
    return int'(total % lim);
`endif
  endfunction

  task automatic push(input logic [63:0] d, input bit l, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    chk("in_ready_before_beat", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int dly, output int s, output int b, output int e);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_latency", n, 0);
    for (int i = 0; i < dly; i++) @(negedge clk);
    s = int'(out_sum);
    b = int'(out_beats);
    e = int'(out_err);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int s, b, e;
    int exp_s;
    logic [63:0] q[$];
    logic [SW-1:0] held_sum;
    logic [CW-1:0] held_beats;

    vecs[0] = '{1,  8'hFF, 1'b1, 2040,  1,  1'b0};
    vecs[1] = '{4,  8'h11, 1'b1, 544,   4,  1'b0};
    vecs[2] = '{16, 8'hFF, 1'b0, 32640, 16, 1'b1};
    vecs[3] = '{16, 8'h01, 1'b1, 128,   16, 1'b0};
    vecs[4] = '{3,  8'h00, 1'b1, 0,     3,  1'b0};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].nbeats; i++)
        push(fill(vecs[v].lane), vecs[v].last && (i == vecs[v].nbeats - 1), 0);
      @(negedge clk);
      chk("vec_in_ready_low", in_ready, 0);
      get_result(2, s, b, e);
      chk($sformatf("vec%0d_sum", v), s, vecs[v].exp_sum);
      chk($sformatf("vec%0d_beats", v), b, vecs[v].exp_beats);
      chk($sformatf("vec%0d_err", v), e, vecs[v].exp_err);
    end

    // Result held while consumer stalls and producer keeps offering beats.
    push(fill(8'h05), 1'b0, 0);
    push(fill(8'h05), 1'b1, 0);
    @(negedge clk);
    held_sum   = out_sum;
    held_beats = out_beats;
    chk("stall_sum_first", held_sum, 80);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum", out_sum, held_sum);
      chk("stall_beats", out_beats, held_beats);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    push(fill(8'h02), 1'b1, 0);
    get_result(0, s, b, e);
    chk("after_stall_sum", s, 16);
    chk("after_stall_beats", b, 1);

    // Reset mid-row discards the partial accumulation.
    push(fill(8'h03), 1'b0, 0);
    push(fill(8'h03), 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_beats", out_beats, 0);
    @(negedge clk);
    rst = 1'b0;
    push(fill(8'h01), 1'b1, 0);
    get_result(0, s, b, e);
    chk("midrst_fresh_sum", s, 8);
    chk("midrst_fresh_beats", b, 1);

    // Narrow accumulator overflow: clamp or wrap depending on build.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v12 = 1'b1;
      d12 = fill(8'hFF);
      l12 = (i == 3);
      @(posedge clk);
      #1;
      v12 = 1'b0;
    end
    @(negedge clk);
    chk("sum12_valid", ov12, 1);
`ifdef SOFTMAX_ACC_SAT_EN
    chk("sum12_sat", sum12, 4095);
`else
    chk("sum12_wrap", sum12, 4064);
`endif
    chk("sum12_beats", beats12, 4);
    r12 = 1'b1;
    @(posedge clk);
    #1;
    r12 = 1'b0;

    for (int r = 0; r < 40; r++) begin
      int len = $urandom_range(1, MAXB);
      bit nolast = (len == MAXB) && ($urandom_range(0, 1) == 1);
      q.delete();
      for (int i = 0; i < len; i++) begin
        q.push_back({$urandom, $urandom});
        push(q[i], !nolast && (i == len - 1), $urandom_range(0, 2));
      end
      exp_s = model_sum(q, SW);
      get_result($urandom_range(0, 3), s, b, e);
      chk($sformatf("rnd%0d_sum", r), s, exp_s);
      chk($sformatf("rnd%0d_beats", r), b, len);
      chk($sformatf("rnd%0d_err", r), e, nolast ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_exp_accum.md
SOFTMAX_EXP_ACCUM -- requirements
Module: softmax_exp_accum

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 16, maximum 64-bit beats per row (8 lanes each; 128 elements).
REQ-002 SHALL have parameter SUM_W, default 16, width of the row-sum output.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  exp beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat.
REQ-007 SHALL have port in_data  input  64  eight unsigned 8-bit exp-LUT outputs; lane k = bits [8k+7:8k].
REQ-008 SHALL have port in_last  input  1  final beat of row.
REQ-009 SHALL have port out_valid  output  1  row result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  SUM_W  sum of all lanes of all row beats.
REQ-012 SHALL have port out_beats  output  $clog2(MAX_BEATS+1)  beats accepted in row.
REQ-013 SHALL have port out_err  output  1  row closed by MAX_BEATS limit, not in_last.

Function
REQ-014 SHALL implement FSM states ACC and OUT; reset state ACC.
REQ-015 Beat accepted when in_valid && in_ready; in_ready SHALL be 1 in ACC, 0 in OUT.
REQ-016 Per accepted beat, the 8 lanes SHALL be zero-extended and summed to an 11-bit beat sum, added to the accumulator in the same cycle; beat counter increments by 1.
REQ-017 On accepted beat with in_last=1, FSM SHALL enter OUT next cycle; out_valid=1, out_sum includes that beat, out_err=0 (latency: 1 cycle from last beat to out_valid).
REQ-018 On accepted beat with in_last=0 that makes the count equal MAX_BEATS, FSM SHALL enter OUT with out_err=1.
REQ-019 Beats with in_last=1 AND reaching MAX_BEATS SHALL close with out_err=0.
REQ-020 In OUT, out_sum/out_beats/out_err SHALL remain stable until out_valid && out_ready.
REQ-021 On output handshake, FSM SHALL return to ACC, accumulator and counter clear to 0 in the same edge; in_ready=1 the following cycle (no input/output overlap).
REQ-022 in_data SHALL be ignored when in_valid=0 or in_ready=0.
REQ-023 Accumulator internal width SHALL be SUM_W+1 bits to detect overflow past 2^SUM_W-1.

Reset
REQ-024 On rst=1, asynchronously: state=ACC, accumulator=0, counter=0, out_valid=0, out_sum=0, out_beats=0, out_err=0, in_ready=1 after rst deasserts.
REQ-025 Reset mid-row or in OUT SHALL discard the partial row/pending result; no output generated for it.

Configuration
REQ-026 With SOFTMAX_ACC_SAT_EN defined, accumulator SHALL clamp at 2^SUM_W-1 and stay there for the row.
REQ-027 Without SOFTMAX_ACC_SAT_EN, accumulator SHALL wrap modulo 2^SUM_W.

Structure
REQ-028 softmax_pkg SHALL hold LANES=8, LANE_W=8, BEAT_SUM_W=11, and the FSM state enum.
REQ-029 Sub-module softmax_lane_adder SHALL be the combinational 8-lane adder tree (64 in, 11 out); all sequencing stays in softmax_exp_accum.

Verification
REQ-030 Single beat all lanes 0xFF, in_last=1 -> next cycle out_valid=1, out_sum=2040, out_beats=1, out_err=0.
REQ-031 Four beats lanes 0x11, last on beat 4 -> out_sum=544, out_beats=4.
REQ-032 16 beats 0xFF without in_last -> out_err=1, out_beats=16, out_sum=32640; in_ready=0 until out_ready.
REQ-033 SUM_W=12, 4 beats 0xFF: SAT_EN -> out_sum=4095; no macro -> out_sum=8160 mod 4096=4064.
REQ-034 out_ready held 0 for 5 cycles with in_valid=1 -> outputs stable, no beats accepted; release -> in_ready=1 next cycle, next row sums from 0.
REQ-035 rst pulsed after 2 of 4 beats -> all outputs 0; fresh 1-beat row of 0x01 yields out_sum=8.
